mem_rr_arbiter: RTL and testbench
=================================

Name: mem_rr_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for one single-port-per-direction coreir_mem instance: one write port, one asynchronous read port.
- Accepts at most one read or write per cycle and returns registered read responses.
- Optionally sweeps the memory to a constant after reset before accepting traffic.
- Sits between client logic and the coreir_mem instance, driving clk/wdata/waddr/wen/raddr and sampling rdata.

Parameters:
- WIDTH, 5, data word width in bits.
- DEPTH, 4, number of memory words (power of two, ≥2).
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.
- CLEAR_ON_RESET, 1, 1 = run the CLEAR sweep after reset; 0 = go straight to SERVE.
- CLEAR_VALUE, 0, WIDTH-bit word written to every entry during CLEAR.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 granted this cycle.
- req0_wen  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_W  address.
- req0_wdata  in  WIDTH  write data.
- rsp0_valid  out  1  read response for requester 0.
- rsp0_rdata  out  WIDTH  read data.
- req1_valid, req1_ready, req1_wen, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: same as requester 0, for requester 1.
- mem_wen  out  1  to coreir_mem wen.
- mem_waddr  out  ADDR_W  to coreir_mem waddr.
- mem_wdata  out  WIDTH  to coreir_mem wdata.
- mem_raddr  out  ADDR_W  to coreir_mem raddr.
- mem_rdata  in  WIDTH  from coreir_mem rdata (combinational read).
- init_done  out  1  high once SERVE is reached.

Behaviour:
- Reset (rst_n=0, immediate):
  - state = CLEAR if CLEAR_ON_RESET else SERVE; clear counter = 0; rr pointer = 0 (requester 0 favoured).
  - req*_ready = 0, rsp*_valid = 0, rsp*_rdata = 0, init_done = CLEAR_ON_RESET ? 0 : 1.
- State CLEAR:
  - Each cycle: mem_wen=1, mem_waddr=counter, mem_wdata=CLEAR_VALUE; counter increments.
  - When counter == DEPTH-1 the write completes and next state = SERVE; takes exactly DEPTH cycles.
  - req*_ready=0 throughout; requests are held by the clients, not dropped.
- State SERVE:
  - init_done=1.
  - Grant is combinational: if exactly one req*_valid, grant it; if both, grant the requester the pointer names.
  - Pointer update: on a grant to requester k, pointer <= 1-k at the clock edge. With no grant, the pointer holds.
  - req_k_ready = grant_k; transfer occurs when valid & ready in the same cycle.
  - Only one requester is granted per cycle.
- Write transfer:
  - mem_wen=1, mem_waddr=addr, mem_wdata=wdata in the same cycle; data is visible to a read on the next cycle.
  - No response is generated.
- Read transfer:
  - mem_raddr=addr combinationally; mem_rdata is captured at the edge.
  - rsp_k_valid=1 with rsp_k_rdata in the following cycle, for exactly one cycle (latency 1).
  - rsp_k_rdata holds its last value afterwards.
- Idle outputs:
  - mem_wen=0 whenever no write is granted (and not in CLEAR).
  - mem_waddr, mem_wdata and mem_raddr are don't-care but driven to 0 when idle.
- No write hazards: one operation per cycle means no same-cycle read/write collision. A read granted the cycle after a write to the same address returns the new data.
- Back-to-back reads to the same requester on consecutive cycles give consecutive rsp pulses; there is no backpressure on the response path.
- Reset asserted mid-CLEAR or mid-read: the state machine restarts and any pending rsp_valid is cancelled. Memory contents are not guaranteed except through a new sweep.
- Addresses ≥ DEPTH cannot occur (ADDR_W = $clog2(DEPTH), DEPTH a power of two). The counter wraps naturally and is not used past DEPTH-1.

Decomposition:
- Shared package mem_arb_pkg: state enum {CLEAR, SERVE}; localparam function for the ADDR_W derivation.
- One natural sub-module, rr_arb2: 2-way round-robin grant plus pointer register, async active-low reset.
- Datapath muxing and the CLEAR FSM stay in the top module.
- Bench and top-level glue instantiate coreir_mem (has_init=0) with WIDTH/DEPTH matched.

Test Plan:
- CLEAR sweep (WIDTH=5, DEPTH=4, CLEAR_VALUE=5'd7): release rst_n → mem_wen=1 at waddr 0,1,2,3 on 4 consecutive cycles, init_done rises on cycle 5, reads of addrs 0–3 all return 7.
- Single write then read: req0 writes 5'd21 to addr 2; next cycle req0 reads addr 2 → rsp0_valid=1 with rsp0_rdata=21 one cycle after the read grant, rsp1_valid stays 0.
- Contention: both valid every cycle, reads to addr 1 (holding 5'd11) → grants alternate 0,1,0,1, each rsp pulses one cycle later with 11, no requester starved.
- Mixed contention: req0 writes 5'd5 to addr 3 while req1 reads addr 3 with pointer=0 → req0 granted first; req1's read granted the next cycle returns 5.
- Requests during CLEAR: req1_valid high from reset release → req1_ready=0 for all 4 CLEAR cycles, granted on the first SERVE cycle.
- Reset mid-operation: assert rst_n=0 in the cycle after a read grant → rsp0_valid never pulses, init_done=0 immediately, and the CLEAR sweep restarts at addr 0 after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for the round-robin memory arbiter
package mem_arb_pkg;

    // Sequencer states: sweep memory to a constant, then serve client traffic
    typedef enum logic {
        CLEAR = 1'b0,
        SERVE = 1'b1
    } arb_state_t;

    // Address width for a given depth; a one-word memory still needs one bit
    function automatic int addr_w_of(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/mem_rr_arbiter_if.sv
// rtl/mem_rr_arbiter_if.sv - per-requester request/response bundle
interface mem_rr_arbiter_if #(
    parameter int WIDTH  = 5,
    parameter int ADDR_W = 2
);
    logic              valid;
    logic              ready;
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  wdata;
    logic              rsp_valid;
    logic [WIDTH-1:0]  rsp_rdata;

    // Client side drives requests and consumes responses
    modport master (
        output valid, wen, addr, wdata,
        input  ready, rsp_valid, rsp_rdata
    );

    // Arbiter side accepts requests and produces responses
    modport slave (
        input  valid, wen, addr, wdata,
        output ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/coreir_mem.sv
// rtl/coreir_mem.sv - memory with one synchronous write port and one asynchronous read port
module coreir_mem #(
    parameter int has_init = 0,
    parameter int width    = 5,
    parameter int depth    = 4,
    localparam int AW      = (depth <= 1) ? 1 : $clog2(depth)
) (
    input  logic             clk,
    input  logic [width-1:0] wdata,
    input  logic [AW-1:0]    waddr,
    input  logic             wen,
    input  logic [AW-1:0]    raddr,
    output logic [width-1:0] rdata
);

    logic [width-1:0] data [depth];

    // Write on the rising edge; the new word is visible to reads the next cycle
    always_ff @(posedge clk) begin
        if (wen) begin
            data[waddr] <= wdata;
        end
    end

    // Read is purely combinational
    assign rdata = data[raddr];

endmodule

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with a favoured-requester pointer
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1,
    output logic ptr
);

    // A lone requester always wins; on contention the pointer picks the winner
    always_comb begin
        gnt0 = en & req0 & (~req1 | ~ptr);
        gnt1 = en & req1 & (~req0 |  ptr);
    end

    // After a grant the other requester becomes favoured; idle cycles hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (gnt0) begin
            ptr <= 1'b1;
        end else if (gnt1) begin
            ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// rtl/mem_rr_arbiter.sv - two-client round-robin sequencer in front of coreir_mem
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int             WIDTH          = 5,
    parameter int             DEPTH          = 4,
    parameter int             CLEAR_ON_RESET = 1,
    parameter logic [WIDTH-1:0] CLEAR_VALUE  = '0,
    localparam int            ADDR_W         = addr_w_of(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_rr_arbiter_if.slave   req0,
    mem_rr_arbiter_if.slave   req1,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic              init_done
);

    arb_state_t        state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              gnt0;
    logic              gnt1;
    logic              rr_ptr;
    logic              any_gnt;
    logic              op_wen;
    logic [ADDR_W-1:0] op_addr;
    logic [WIDTH-1:0]  op_wdata;
    logic              rd0_fire;
    logic              rd1_fire;
    logic              rsp0_valid_q;
    logic              rsp1_valid_q;
    logic [WIDTH-1:0]  rsp0_rdata_q;
    logic [WIDTH-1:0]  rsp1_rdata_q;

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == SERVE),
        .req0  (req0.valid),
        .req1  (req1.valid),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .ptr   (rr_ptr)
    );

    // Sequencer: sweep every word once after reset, then serve forever
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= (CLEAR_ON_RESET != 0) ? CLEAR : SERVE;
            clr_cnt   <= '0;
            init_done <= (CLEAR_ON_RESET == 0);
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                        state     <= SERVE;
                        init_done <= 1'b1;
                    end
                end
                default: begin
                    init_done <= 1'b1;
                end
            endcase
        end
    end

    // Select the granted requester's operation fields
    always_comb begin
        any_gnt  = gnt0 | gnt1;
        op_wen   = gnt1 ? req1.wen   : req0.wen;
        op_addr  = gnt1 ? req1.addr  : req0.addr;
        op_wdata = gnt1 ? req1.wdata : req0.wdata;
        rd0_fire = gnt0 & ~req0.wen;
        rd1_fire = gnt1 & ~req1.wen;
    end

    // Memory port drive: sweep writes, granted write, granted read, else all zero
    always_comb begin
        mem_wen   = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        mem_raddr = '0;
        if (state == CLEAR) begin
            mem_wen   = 1'b1;
            mem_waddr = clr_cnt;
            mem_wdata = CLEAR_VALUE;
        end else if (any_gnt && op_wen) begin
            mem_wen   = 1'b1;
            mem_waddr = op_addr;
            mem_wdata = op_wdata;
        end else if (any_gnt) begin
            mem_raddr = op_addr;
        end
    end

    // Register read data for one-cycle response pulses; data holds between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            rsp0_valid_q <= rd0_fire;
            rsp1_valid_q <= rd1_fire;
            if (rd0_fire) begin
                rsp0_rdata_q <= mem_rdata;
            end
            if (rd1_fire) begin
                rsp1_rdata_q <= mem_rdata;
            end
        end
    end

    assign req0.ready     = gnt0;
    assign req1.ready     = gnt1;
    assign req0.rsp_valid = rsp0_valid_q;
    assign req1.rsp_valid = rsp1_valid_q;
    assign req0.rsp_rdata = rsp0_rdata_q;
    assign req1.rsp_rdata = rsp1_rdata_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb/tb_mem_rr_arbiter.sv - randomized and directed checks of the round-robin memory arbiter
module tb_mem_rr_arbiter;

    localparam int         WIDTH  = 5;
    localparam int         DEPTH  = 4;
    localparam int         ADDR_W = 2;
    localparam logic [4:0] CV     = 5'd7;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mem_rr_arbiter_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) r0 ();
    mem_rr_arbiter_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) r1 ();

    logic              mem_wen;
    logic [ADDR_W-1:0] mem_waddr;
    logic [ADDR_W-1:0] mem_raddr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  mem_rdata;
    logic              init_done;

    mem_rr_arbiter #(
        .WIDTH          (WIDTH),
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (1),
        .CLEAR_VALUE    (CV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (r0.slave),
        .req1      (r1.slave),
        .mem_wen   (mem_wen),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .init_done (init_done)
    );

    coreir_mem #(.has_init(0), .width(WIDTH), .depth(DEPTH)) u_mem (
        .clk   (clk),
        .wdata (mem_wdata),
        .waddr (mem_waddr),
        .wen   (mem_wen),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: memory contents, favoured requester, expected responses
    logic [4:0] mmem [DEPTH];
    int         mptr;
    logic       erv0, erv1;
    logic [4:0] erd0, erd1;

    task automatic drive(input logic v0, input logic w0, input logic [1:0] a0, input logic [4:0] d0,
                         input logic v1, input logic w1, input logic [1:0] a1, input logic [4:0] d1);
        r0.valid = v0; r0.wen = w0; r0.addr = a0; r0.wdata = d0;
        r1.valid = v1; r1.wen = w1; r1.addr = a1; r1.wdata = d1;
    endtask

    task automatic next;
        @(posedge clk);
        #1;
    endtask

    // Who should win this cycle, from the request lines and the favoured requester
    function automatic int exp_grant();
        if (r0.valid && r1.valid) return mptr;
        if (r0.valid) return 0;
        if (r1.valid) return 1;
        return -1;
    endfunction

    // Apply the effect of the upcoming clock edge to the model
    task automatic model_step(input int g);
        logic       w;
        logic [1:0] a;
        logic [4:0] d;
        erv0 = 1'b0;
        erv1 = 1'b0;
        if (g >= 0) begin
            w = (g == 1) ? r1.wen   : r0.wen;
            a = (g == 1) ? r1.addr  : r0.addr;
            d = (g == 1) ? r1.wdata : r0.wdata;
            if (w) mmem[a] = d;
            else if (g == 0) begin erv0 = 1'b1; erd0 = mmem[a]; end
            else begin erv1 = 1'b1; erd1 = mmem[a]; end
            mptr = 1 - g;
        end
    endtask

    task automatic test_reset;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done got %b want 0", init_done); end
        checks++; if (r0.ready !== 1'b0 || r1.ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b%b want 00", r0.ready, r1.ready); end
        checks++; if (r0.rsp_valid !== 1'b0 || r1.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b%b want 00", r0.rsp_valid, r1.rsp_valid); end
        checks++; if (r0.rsp_rdata !== 5'd0 || r1.rsp_rdata !== 5'd0) begin errors++; $display("FAIL rst_rsp_rdata got %0d/%0d want 0/0", r0.rsp_rdata, r1.rsp_rdata); end
    endtask

    // Sweep after reset while requester 1 holds a read of address 0
    task automatic test_clear;
        drive(0, 0, 0, 0, 1, 0, 2'd0, 0);
        next;
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            checks++; if (mem_wen !== 1'b1 || mem_waddr !== 2'(i) || mem_wdata !== CV) begin errors++; $display("FAIL clear_write[%0d] got wen=%b addr=%0d data=%0d want 1/%0d/%0d", i, mem_wen, mem_waddr, mem_wdata, i, CV); end
            checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL clear_init_done[%0d] got %b want 0", i, init_done); end
            checks++; if (r1.ready !== 1'b0) begin errors++; $display("FAIL clear_hold_ready[%0d] got %b want 0", i, r1.ready); end
            next;
        end
        @(negedge clk);
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL serve_init_done got %b want 1", init_done); end
        checks++; if (r1.ready !== 1'b1 || mem_raddr !== 2'd0) begin errors++; $display("FAIL first_serve_grant got ready=%b raddr=%0d want 1/0", r1.ready, mem_raddr); end
        next;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (r1.rsp_valid !== 1'b1 || r1.rsp_rdata !== CV) begin errors++; $display("FAIL first_serve_rsp got v=%b d=%0d want 1/%0d", r1.rsp_valid, r1.rsp_rdata, CV); end
        next;
    endtask

    task automatic test_clear_readback;
        for (int a = 0; a < DEPTH; a++) begin
            drive(1, 0, 2'(a), 0, 0, 0, 0, 0);
            @(negedge clk);
            checks++; if (r0.ready !== 1'b1) begin errors++; $display("FAIL rb_ready[%0d] got %b want 1", a, r0.ready); end
            next;
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            checks++; if (r0.rsp_valid !== 1'b1 || r0.rsp_rdata !== CV) begin errors++; $display("FAIL rb_data[%0d] got v=%b d=%0d want 1/%0d", a, r0.rsp_valid, r0.rsp_rdata, CV); end
            next;
        end
    endtask

    task automatic test_write_read;
        drive(1, 1, 2'd2, 5'd21, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (r0.ready !== 1'b1 || mem_wen !== 1'b1 || mem_waddr !== 2'd2 || mem_wdata !== 5'd21) begin errors++; $display("FAIL wr_port got rdy=%b wen=%b a=%0d d=%0d want 1/1/2/21", r0.ready, mem_wen, mem_waddr, mem_wdata); end
        next;
        drive(1, 0, 2'd2, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (r0.ready !== 1'b1 || mem_wen !== 1'b0 || mem_raddr !== 2'd2) begin errors++; $display("FAIL rd_port got rdy=%b wen=%b ra=%0d want 1/0/2", r0.ready, mem_wen, mem_raddr); end
        checks++; if (r0.rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_no_rsp got %b want 0", r0.rsp_valid); end
        next;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (r0.rsp_valid !== 1'b1 || r0.rsp_rdata !== 5'd21 || r1.rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_rd_rsp got v0=%b d0=%0d v1=%b want 1/21/0", r0.rsp_valid, r0.rsp_rdata, r1.rsp_valid); end
        checks++; if (mem_wen !== 1'b0 || mem_waddr !== 2'd0 || mem_raddr !== 2'd0 || mem_wdata !== 5'd0) begin errors++; $display("FAIL idle_port got wen=%b wa=%0d ra=%0d wd=%0d want 0/0/0/0", mem_wen, mem_waddr, mem_raddr, mem_wdata); end
        next;
        @(negedge clk);
        checks++; if (r0.rsp_valid !== 1'b0 || r0.rsp_rdata !== 5'd21) begin errors++; $display("FAIL rsp_hold got v=%b d=%0d want 0/21", r0.rsp_valid, r0.rsp_rdata); end
        next;
    endtask

    // Requester 1 seeds addr 1, then both contend for reads of it
    task automatic test_contention;
        drive(0, 0, 0, 0, 1, 1, 2'd1, 5'd11);
        @(negedge clk);
        checks++; if (r1.ready !== 1'b1) begin errors++; $display("FAIL cont_seed got %b want 1", r1.ready); end
        next;
        drive(1, 0, 2'd1, 0, 1, 0, 2'd1, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if (r0.ready !== (i % 2 == 0) || r1.ready !== (i % 2 == 1)) begin errors++; $display("FAIL cont_grant[%0d] got %b%b want %b%b", i, r0.ready, r1.ready, (i % 2 == 0), (i % 2 == 1)); end
            if (i > 0) begin
                checks++; if (r0.rsp_valid !== (i % 2 == 1) || r1.rsp_valid !== (i % 2 == 0) || (i % 2 == 1 ? r0.rsp_rdata : r1.rsp_rdata) !== 5'd11) begin errors++; $display("FAIL cont_rsp[%0d] got v=%b%b d=%0d/%0d want 11", i, r0.rsp_valid, r1.rsp_valid, r0.rsp_rdata, r1.rsp_rdata); end
            end
            next;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (r1.rsp_valid !== 1'b1 || r1.rsp_rdata !== 5'd11 || r0.rsp_valid !== 1'b0) begin errors++; $display("FAIL cont_last got v=%b%b d1=%0d want 01/11", r0.rsp_valid, r1.rsp_valid, r1.rsp_rdata); end
        next;
    endtask

    task automatic test_mixed;
        drive(1, 1, 2'd3, 5'd5, 1, 0, 2'd3, 0);
        @(negedge clk);
        checks++; if (r0.ready !== 1'b1 || r1.ready !== 1'b0 || mem_wen !== 1'b1) begin errors++; $display("FAIL mixed_first got %b%b wen=%b want 10/1", r0.ready, r1.ready, mem_wen); end
        next;
        drive(0, 0, 0, 0, 1, 0, 2'd3, 0);
        @(negedge clk);
        checks++; if (r1.ready !== 1'b1 || mem_raddr !== 2'd3) begin errors++; $display("FAIL mixed_second got rdy=%b ra=%0d want 1/3", r1.ready, mem_raddr); end
        next;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (r1.rsp_valid !== 1'b1 || r1.rsp_rdata !== 5'd5 || r0.rsp_valid !== 1'b0) begin errors++; $display("FAIL mixed_rsp got v=%b%b d=%0d want 01/5", r0.rsp_valid, r1.rsp_valid, r1.rsp_rdata); end
        next;
    endtask

    task automatic test_random;
        int         g;
        logic       ew;
        logic [1:0] ea;
        logic [4:0] ed;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        next;
        rst_n = 1'b1;
        repeat (DEPTH) next;
        for (int i = 0; i < DEPTH; i++) mmem[i] = CV;
        mptr = 0; erv0 = 0; erv1 = 0; erd0 = 0; erd1 = 0;
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom), 2'($urandom), 5'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom), 2'($urandom), 5'($urandom));
            @(negedge clk);
            g  = exp_grant();
            ew = (g == 0) ? r0.wen : (g == 1) ? r1.wen : 1'b0;
            ea = (g == 0) ? r0.addr : (g == 1) ? r1.addr : 2'd0;
            ed = (g == 0) ? r0.wdata : (g == 1) ? r1.wdata : 5'd0;
            checks++; if (r0.ready !== (g == 0) || r1.ready !== (g == 1)) begin errors++; $display("FAIL rnd_grant[%0d] got %b%b want grant %0d", n, r0.ready, r1.ready, g); end
            checks++; if (r0.rsp_valid !== erv0 || r0.rsp_rdata !== erd0) begin errors++; $display("FAIL rnd_rsp0[%0d] got %b/%0d want %b/%0d", n, r0.rsp_valid, r0.rsp_rdata, erv0, erd0); end
            checks++; if (r1.rsp_valid !== erv1 || r1.rsp_rdata !== erd1) begin errors++; $display("FAIL rnd_rsp1[%0d] got %b/%0d want %b/%0d", n, r1.rsp_valid, r1.rsp_rdata, erv1, erd1); end
            checks++; if (mem_wen !== ew || mem_waddr !== (ew ? ea : 2'd0) || mem_wdata !== (ew ? ed : 5'd0)) begin errors++; $display("FAIL rnd_wport[%0d] got %b/%0d/%0d want %b/%0d/%0d", n, mem_wen, mem_waddr, mem_wdata, ew, ew ? ea : 2'd0, ew ? ed : 5'd0); end
            checks++; if (mem_raddr !== ((g >= 0 && !ew) ? ea : 2'd0)) begin errors++; $display("FAIL rnd_raddr[%0d] got %0d want %0d", n, mem_raddr, (g >= 0 && !ew) ? ea : 2'd0); end
            model_step(g);
            next;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        next;
    endtask

    task automatic test_reset_mid;
        drive(1, 0, 2'd0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (r0.ready !== 1'b1) begin errors++; $display("FAIL mid_grant got %b want 1", r0.ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (r0.rsp_valid !== 1'b0 || init_done !== 1'b0) begin errors++; $display("FAIL mid_cancel got v=%b init=%b want 0/0", r0.rsp_valid, init_done); end
        checks++; if (mem_wen !== 1'b1 || mem_waddr !== 2'd0) begin errors++; $display("FAIL mid_sweep_start got %b/%0d want 1/0", mem_wen, mem_waddr); end
        next;
        @(negedge clk);
        checks++; if (r0.rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_hold got %b want 0", r0.rsp_valid); end
        next;
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            checks++; if (mem_wen !== 1'b1 || mem_waddr !== 2'(i) || init_done !== 1'b0 || r0.rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_resweep[%0d] got wen=%b a=%0d init=%b v=%b", i, mem_wen, mem_waddr, init_done, r0.rsp_valid); end
            next;
        end
        @(negedge clk);
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL mid_done got %b want 1", init_done); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_clear;
        test_clear_readback;
        test_write_read;
        test_contention;
        test_mixed;
        test_random;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
